// File: rtl/minutnik.sv
// Cooking timer: BCD mm:ss load via two buttons, countdown while heat is high,
// raises finish when the time is spent.
module minutnik #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       add_min,
  input  logic       add_10s,
  input  logic       clear,
  input  logic       heat,
  output logic       finish,
  output logic [3:0] mm_tens,
  output logic [3:0] mm_ones,
  output logic [3:0] ss_tens,
  output logic [3:0] ss_ones,
  output logic       zero
);

  localparam int CW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt;
  logic          prev_min;
  logic          prev_10s;

  logic       press_min;
  logic       press_10s;
  logic       press;
  logic       tick;

  logic [3:0] st_add;
  logic       c10;
  logic [1:0] madd;
  logic [4:0] mo_sum;
  logic [3:0] mo_add;
  logic       mo_c;
  logic       sat;
  logic [3:0] mt_add;

  logic [3:0] so_dec;
  logic [3:0] st_dec;
  logic [3:0] mo_dec;
  logic [3:0] mt_dec;

  assign zero      = (mm_tens == 4'd0) && (mm_ones == 4'd0) &&
                     (ss_tens == 4'd0) && (ss_ones == 4'd0);
  assign press_min = add_min & ~prev_min;
  assign press_10s = add_10s & ~prev_10s;
  assign press     = press_min | press_10s;
  assign tick      = heat & ~zero & (cnt == LAST);

  // Press arithmetic: ten seconds carry into minutes, minutes overflow saturates
  always_comb begin
    st_add = ss_tens;
    c10    = 1'b0;
    if (press_10s) begin
      if (ss_tens == 4'd5) begin
        st_add = 4'd0;
        c10    = 1'b1;
      end else begin
        st_add = ss_tens + 4'd1;
      end
    end
    madd   = {1'b0, press_min} + {1'b0, c10};
    mo_sum = {1'b0, mm_ones} + {3'b000, madd};
    mo_c   = (mo_sum >= 5'd10);
    mo_add = mo_c ? 4'(mo_sum - 5'd10) : mo_sum[3:0];
    sat    = mo_c && (mm_tens == 4'd9);
    mt_add = mm_tens + {3'b000, mo_c};
  end

  // One-second BCD borrow chain; only used while time is non-zero
  always_comb begin
    so_dec = ss_ones;
    st_dec = ss_tens;
    mo_dec = mm_ones;
    mt_dec = mm_tens;
    if (ss_ones != 4'd0) begin
      so_dec = ss_ones - 4'd1;
    end else begin
      so_dec = 4'd9;
      if (ss_tens != 4'd0) begin
        st_dec = ss_tens - 4'd1;
      end else begin
        st_dec = 4'd5;
        if (mm_ones != 4'd0) begin
          mo_dec = mm_ones - 4'd1;
        end else begin
          mo_dec = 4'd9;
          mt_dec = mm_tens - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mm_tens  <= 4'd0;
      mm_ones  <= 4'd0;
      ss_tens  <= 4'd0;
      ss_ones  <= 4'd0;
      cnt      <= '0;
      finish   <= 1'b0;
      prev_min <= 1'b1;
      prev_10s <= 1'b1;
    end else begin
      prev_min <= add_min;
      prev_10s <= add_10s;
      if (clear) begin
        mm_tens <= 4'd0;
        mm_ones <= 4'd0;
        ss_tens <= 4'd0;
        ss_ones <= 4'd0;
        cnt     <= '0;
        finish  <= 1'b0;
      end else begin
        if (zero)
          cnt <= '0;
        else if (heat)
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        if (press) begin
          finish <= 1'b0;
          if (sat) begin
            mm_tens <= 4'd9;
            mm_ones <= 4'd9;
            ss_tens <= 4'd5;
            ss_ones <= 4'd9;
          end else begin
            mm_tens <= mt_add;
            mm_ones <= mo_add;
            ss_tens <= st_add;
          end
        end else begin
          if (tick) begin
            mm_tens <= mt_dec;
            mm_ones <= mo_dec;
            ss_tens <= st_dec;
            ss_ones <= so_dec;
          end
          if (heat && zero)
            finish <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_minutnik.sv
// Self-checking bench for minutnik: directed test plan plus random traffic,
// compared against a seconds-based reference model.
module tb_minutnik;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       add_min = 1'b0;
  logic       add_10s = 1'b0;
  logic       clear = 1'b0;
  logic       heat = 1'b0;
  logic       finish;
  logic [3:0] mm_tens;
  logic [3:0] mm_ones;
  logic [3:0] ss_tens;
  logic [3:0] ss_ones;
  logic       zero;

  int total = 0;
  int fails = 0;

  // Reference model: remaining time in whole seconds
  int m_t = 0;
  int m_p = 0;
  bit m_fin = 0;
  bit m_pm = 1;
  bit m_pt = 1;

  minutnik #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .rst(rst), .add_min(add_min), .add_10s(add_10s),
    .clear(clear), .heat(heat), .finish(finish),
    .mm_tens(mm_tens), .mm_ones(mm_ones),
    .ss_tens(ss_tens), .ss_ones(ss_ones), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(int secs);
    int mm;
    int ss;
    mm = secs / 60;
    ss = secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic model_edge();
    bit pmin;
    bit p10;
    bit z;
    bit tk;
    if (rst) begin
      m_t = 0; m_p = 0; m_fin = 0; m_pm = 1; m_pt = 1;
      return;
    end
    pmin = add_min && !m_pm;
    p10  = add_10s && !m_pt;
    m_pm = add_min;
    m_pt = add_10s;
    z = (m_t == 0);
    if (clear) begin
      m_t = 0; m_p = 0; m_fin = 0;
      return;
    end
    tk = heat && !z && (m_p == T - 1);
    if (z) m_p = 0;
    else if (heat) m_p = (m_p + 1) % T;
    if (pmin || p10) begin
      m_t = m_t + 60 * int'(pmin) + 10 * int'(p10);
      if (m_t > 5999) m_t = 5999;
      m_fin = 0;
    end else begin
      if (tk) m_t = m_t - 1;
      if (heat && z) m_fin = 1;
    end
  endtask

  task automatic check_model(string tag);
    logic [15:0] got;
    got = {mm_tens, mm_ones, ss_tens, ss_ones};
    total++;
    assert (got === to_bcd(m_t)) else begin
      fails++;
      $error("FAIL %s time got %h want %h", tag, got, to_bcd(m_t));
    end
    total++;
    assert (finish === m_fin) else begin
      fails++;
      $error("FAIL %s finish got %b want %b", tag, finish, m_fin);
    end
    total++;
    assert (zero === (m_t == 0)) else begin
      fails++;
      $error("FAIL %s zero got %b want %b", tag, zero, m_t == 0);
    end
  endtask

  task automatic expect_const(string tag, logic [15:0] bcd, logic fin);
    logic [15:0] got;
    got = {mm_tens, mm_ones, ss_tens, ss_ones};
    total++;
    assert (got === bcd) else begin
      fails++;
      $error("FAIL %s time got %h want %h", tag, got, bcd);
    end
    total++;
    assert (finish === fin) else begin
      fails++;
      $error("FAIL %s finish got %b want %b", tag, finish, fin);
    end
  endtask

  task automatic step(string tag, int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_model(tag);
    end
  endtask

  task automatic pulse_min(int n);
    for (int i = 0; i < n; i++) begin
      add_min = 1'b1; step("pmin");
      add_min = 1'b0; step("pmin");
    end
  endtask

  task automatic pulse_10s(int n);
    for (int i = 0; i < n; i++) begin
      add_10s = 1'b1; step("p10s");
      add_10s = 1'b0; step("p10s");
    end
  endtask

  task automatic do_clear();
    clear = 1'b1; step("clear");
    clear = 1'b0;
  endtask

  initial begin
    // Reset with add_min held
    rst = 1'b1; add_min = 1'b1;
    step("reset", 2);
    expect_const("reset", 16'h0000, 1'b0);
    total++;
    assert (zero === 1'b1) else begin
      fails++;
      $error("FAIL reset_zero got %b want 1", zero);
    end
    rst = 1'b0;
    step("held", 3);
    expect_const("held_no_press", 16'h0000, 1'b0);
    add_min = 1'b0; step("rel");
    add_min = 1'b1; step("repress");
    expect_const("repress", 16'h0100, 1'b0);
    add_min = 1'b0;
    do_clear();

    // Loading
    pulse_10s(7);
    expect_const("load_110", 16'h0110, 1'b0);
    add_min = 1'b1; step("hold", 5); add_min = 1'b0; step("hold");
    expect_const("load_210", 16'h0210, 1'b0);
    add_min = 1'b1; add_10s = 1'b1; step("both");
    add_min = 1'b0; add_10s = 1'b0;
    expect_const("load_320", 16'h0320, 1'b0);

    // Borrow
    do_clear();
    pulse_min(1);
    heat = 1'b1;
    step("cnt", 3);
    expect_const("pre_tick", 16'h0100, 1'b0);
    step("cnt");
    expect_const("borrow_59", 16'h0059, 1'b0);
    step("cnt", 4);
    expect_const("tick_58", 16'h0058, 1'b0);
    heat = 1'b0;

    // Pause keeps partial second
    do_clear();
    pulse_min(1);
    heat = 1'b1; step("run", 2);
    heat = 1'b0; step("pause", 10);
    expect_const("paused", 16'h0100, 1'b0);
    heat = 1'b1; step("resume");
    expect_const("resume1", 16'h0100, 1'b0);
    step("resume");
    expect_const("resume2", 16'h0059, 1'b0);
    heat = 1'b0;

    // Finish
    do_clear();
    pulse_10s(1);
    heat = 1'b1;
    step("down", 40);
    expect_const("spent", 16'h0000, 1'b0);
    step("fin");
    expect_const("finish", 16'h0000, 1'b1);
    heat = 1'b0; step("fin_hold", 3);
    expect_const("fin_hold", 16'h0000, 1'b1);
    add_10s = 1'b1; step("fin_cancel");
    add_10s = 1'b0;
    expect_const("fin_cancel", 16'h0010, 1'b0);

    // Saturation
    do_clear();
    pulse_min(99);
    expect_const("sat_9900", 16'h9900, 1'b0);
    pulse_10s(5);
    expect_const("sat_9950", 16'h9950, 1'b0);
    pulse_10s(1);
    expect_const("sat_9959", 16'h9959, 1'b0);
    pulse_10s(1);
    expect_const("sat_hold", 16'h9959, 1'b0);
    heat = 1'b1; step("sat_cnt", 4);
    expect_const("sat_9958", 16'h9958, 1'b0);
    heat = 1'b0;

    // Start at 00:00
    do_clear();
    heat = 1'b1; step("z_start");
    expect_const("zero_start", 16'h0000, 1'b1);
    heat = 1'b0;

    // clear beats a press and cancels finish
    clear = 1'b1; add_min = 1'b1; step("clr_press");
    clear = 1'b0; add_min = 1'b0;
    expect_const("clr_press", 16'h0000, 1'b0);
    step("idle");

    // Tick discarded by a coinciding press
    pulse_10s(3);
    heat = 1'b1; step("tp", 3);
    expect_const("tp_pre", 16'h0030, 1'b0);
    add_10s = 1'b1; step("tp");
    add_10s = 1'b0;
    expect_const("tp_press", 16'h0040, 1'b0);
    step("tp", 3);
    expect_const("tp_wrap", 16'h0040, 1'b0);
    step("tp");
    expect_const("tp_tick", 16'h0039, 1'b0);
    heat = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 999) == 0);
      clear   = ($urandom_range(0, 199) == 0);
      add_min = ($urandom_range(0, 149) == 0);
      add_10s = ($urandom_range(0, 29) == 0);
      heat    = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/minutnik.md
# minutnik

Cooking timer that sits directly upstream of the microwave oven controller. The user loads a cook time as BCD minutes:seconds with two buttons. The timer counts down one second per tick while the controller's `heat` output is high, and freezes while `heat` is low (door-open pause). When the time is spent it raises `finish`, which drives the controller's `finish` input. It also presents the remaining time as four BCD digits for the display stage.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clk cycles per second, ≥2; the bench uses 4.
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `add_min` in 1: button, add one minute; level input, acts on its rising edge.
- `add_10s` in 1: button, add ten seconds; level input, acts on its rising edge.
- `clear` in 1: level input; load 00:00, cancel `finish`.
- `heat` in 1: from the oven controller; countdown enable.
- `finish` out 1: registered; time spent while cooking; drives the controller's `finish`.
- `mm_tens`, `mm_ones`, `ss_tens`, `ss_ones` out 4 each: registered BCD remaining time.
- `zero` out 1: combinational; high when all four digits are 0.

## Operation
- Time range is 00:00..99:59. `ss_tens` is always 0..5; every other digit is always 0..9.
- Button edge detect: a press is button=1 at an edge with the previous sample 0.
  - The previous-sample registers reset to 1, so a button held through reset does not fire.
  - Holding a button gives exactly one press.
- Per-edge priority: `rst` > `clear` > presses > countdown tick.
- `clear`:
  - Time becomes 00:00, prescaler 0, `finish` 0.
  - Presses in the same cycle are ignored; their edge-detect registers still update.
- `add_10s` press: time += 0:10, with BCD carry from `ss_tens` into minutes.
- `add_min` press: minutes += 1; seconds unchanged.
- Both presses in one cycle add 1:10.
- Saturation: any result above 99:59 loads exactly 99:59.
- Any press clears `finish`, even if the time saturates unchanged.
- Prescaler (0..TICKS_PER_SEC-1):
  - Increments each cycle with `heat`=1 and `zero`=0.
  - Holds its value when `heat`=0, so a pause preserves the partial second.
  - Resets to 0 when time is 00:00.
- Tick: prescaler == TICKS_PER_SEC-1 while counting. The prescaler wraps to 0 and time -= 0:01 with BCD borrow:
  - `ss_ones` 0→9 borrows from `ss_tens`.
  - `ss_tens` 0→5 borrows from `mm_ones`.
  - `mm_ones` 0→9 borrows from `mm_tens`.
- A tick coinciding with a press is discarded; the prescaler still wraps to 0.
- `finish` set rule: set at any edge where `heat`=1 and `zero`=1, unless `clear` or a press occurs at that edge.
  - This also covers a start with 00:00, which finishes immediately.
- `finish` stays high, regardless of `heat`, until `rst`, `clear` or a press.

## Timing
- Reset values: all digits 0, `zero` 1, `finish` 0, prescaler 0.
- Press latency: button sampled high at edge k → new digits visible after edge k.
- First tick: `heat` rises before edge 1 with prescaler 0 → decrement visible after edge TICKS_PER_SEC. Each later tick follows TICKS_PER_SEC counting cycles later.
- `finish` latency: time shows 00:00 after edge k (with `heat`=1) → `finish` high after edge k+1. The controller sees it at edge k+2.
- `rst` mid-count: everything returns to reset values at that edge and no tick occurs.
- Inputs are synchronous to `clk`; no internal synchronisers or debouncing.

## Test plan
All scenarios use TICKS_PER_SEC=4.
- Reset: assert `rst` 2 cycles with `add_min` held high → 00:00, `finish`=0, `zero`=1. After release, no minute is added until `add_min` drops and rises again.
- Loading: 7 single-cycle `add_10s` pulses → 01:10. Then `add_min` held 5 cycles → 02:10. Then both pulsed in one cycle → 03:20.
- Borrow and pause:
  - Load 01:00, `heat`=1 → 00:59 after 4 edges, 00:58 after 8.
  - From a fresh 01:00: `heat`=1 for 2 cycles, 0 for 10 (time stays 01:00), 1 again → 00:59 after exactly 2 more edges.
- Finish: load 00:10, `heat`=1 → 00:00 after 40 edges, `finish`=1 one edge later. `finish` stays 1 after `heat` drops. An `add_10s` pulse → 00:10, `finish`=0.
- Saturation: 99 `add_min` pulses → 99:00. 5 `add_10s` pulses → 99:50. One more → 99:59. One more → 99:59 unchanged. With `heat`=1, 4 edges → 99:58.
- Edge cases:
  - 00:00 with `heat`=1 → `finish`=1 one edge later.
  - `clear` and `add_min` in the same cycle → 00:00, `finish`=0.
  - A tick coinciding with an `add_10s` press (from 00:30) → 00:40 with prescaler 0.
